// File: rtl/bmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bmem_pkg
// Purpose  : Shared types and constants for the bmem responder: beat/line
//            geometry, write/read FSM state encodings and the read-queue entry.
// Revision : 1.0  initial release
// ============================================================================
package bmem_pkg;

  localparam int BMEM_BEATS      = 4;
  localparam int BMEM_BEAT_W     = 64;
  localparam int BMEM_LINE_BYTES = 32;
  localparam int BMEM_LINE_SHIFT = $clog2(BMEM_LINE_BYTES);
  // Widest line address a queue entry can carry (64-bit byte address >> 5).
  localparam int BMEM_LINE_AW    = 64 - BMEM_LINE_SHIFT;
  // Ages saturate at LATENCY, which tops out at 255.
  localparam int BMEM_AGE_W      = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_B1   = 2'd1,
    W_B2   = 2'd2,
    W_B3   = 2'd3
  } wr_state_t;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_BEAT0 = 3'd1,
    R_BEAT1 = 3'd2,
    R_BEAT2 = 3'd3,
    R_BEAT3 = 3'd4
  } rd_state_t;

  typedef struct packed {
    logic [BMEM_LINE_AW-1:0] line;
    logic [BMEM_AGE_W-1:0]   age;
  } rd_req_t;

  // Beat number carried by a read-return state (R_IDLE maps to beat 0).
  function automatic logic [1:0] rd_beat_idx(input rd_state_t s);
    logic [1:0] b;
    case (s)
      R_BEAT1: b = 2'd1;
      R_BEAT2: b = 2'd2;
      R_BEAT3: b = 2'd3;
      default: b = 2'd0;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmem_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : bmem_req_queue
// Purpose  : Circular FIFO of outstanding line reads. Every entry carries an
//            age that counts up each cycle (saturating at LATENCY); the head
//            and the entry behind it report when they may start returning.
// Revision : 1.0  initial release
// ============================================================================
module bmem_req_queue
  import bmem_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [BMEM_LINE_AW-1:0] push_line,
  input  logic                    pop,
  output logic                    full,
  output logic                    full_next,
  output logic                    empty,
  output logic [BMEM_LINE_AW-1:0] head_line,
  output logic                    head_ready,
  output logic [BMEM_LINE_AW-1:0] second_line,
  output logic                    second_ready
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [BMEM_AGE_W-1:0] AGE_MAX = BMEM_AGE_W'(LATENCY);
  // The push register and the output register each add one cycle, so an
  // entry may launch its first beat two ages early and still land exactly
  // LATENCY cycles after the request was accepted.
  localparam logic [BMEM_AGE_W-1:0] AGE_FIRE = BMEM_AGE_W'(LATENCY - 2);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0]      CNT_TWO  = CNT_W'(2);

  rd_req_t          entries [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] second_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign second_ptr = rd_ptr + 1'b1;

  assign head_line    = entries[rd_ptr].line;
  assign head_ready   = !empty && (entries[rd_ptr].age >= AGE_FIRE);
  assign second_line  = entries[second_ptr].line;
  assign second_ready = (count >= CNT_TWO) && (entries[second_ptr].age >= AGE_FIRE);

  // Occupancy after this cycle's push/pop, used to register the ready flag.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count - 1'b1;
    end
  end

  assign full_next = (count_next == CNT_FULL);

  // Pointer/occupancy update, per-entry saturating age and entry capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        entries[i].line <= '0;
        entries[i].age  <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (entries[i].age != AGE_MAX) begin
          entries[i].age <= entries[i].age + 1'b1;
        end
      end
      if (push_ok) begin
        entries[wr_ptr].line <= push_line;
        entries[wr_ptr].age  <= '0;
        wr_ptr               <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : bmem_responder
// Purpose  : Memory-side responder for the 64-bit burst memory interface.
//            Takes single-cycle line reads and 4-beat write bursts, owns a
//            4-bank backing RAM and returns 4-beat line reads in request order
//            after a fixed latency.
// Options  : BMEM_RANDOM_STALL_EN - LFSR-driven random deassertion of
//            bmem_ready while no write burst is in flight.
// Revision : 1.0  initial release
// ============================================================================
module bmem_responder
  import bmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 8,
  parameter int QDEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bmem_addr,
  input  logic              bmem_read,
  input  logic              bmem_write,
  input  logic [63:0]       bmem_wdata,
  output logic              bmem_ready,
  output logic [ADDR_W-1:0] bmem_raddr,
  output logic [63:0]       bmem_rdata,
  output logic              bmem_rvalid,
  output logic              proto_err
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int LINE_W = ADDR_W - BMEM_LINE_SHIFT;

  wr_state_t wr_state;
  wr_state_t wr_next;
  rd_state_t rd_state;
  rd_state_t rd_next;

  logic [IDX_W-1:0]        wr_line_idx;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_idx;
  logic [1:0]              wr_beat;
  logic                    wr_en;
  logic                    wr_start;
  logic                    wr_abort;
  logic                    collide;
  logic                    rd_accept;
  logic                    ready_next;
  logic                    stall;

  logic [BMEM_LINE_AW-1:0] req_line;
  logic [BMEM_LINE_AW-1:0] rd_line;
  logic [BMEM_LINE_AW-1:0] head_line;
  logic [BMEM_LINE_AW-1:0] second_line;
  logic                    q_full;
  logic                    q_full_next;
  logic                    q_empty;
  logic                    head_ready;
  logic                    second_ready;
  logic                    pop;

  logic [BMEM_BEAT_W-1:0]  bank_rd [BMEM_BEATS];

  logic                    unused_addr_lo;
  logic                    unused_line_hi;

  assign unused_addr_lo = ^bmem_addr[BMEM_LINE_SHIFT-1:0];
  assign unused_line_hi = ^rd_line[BMEM_LINE_AW-1:LINE_W];

  // Request address reduced to a line address, zero-extended to queue width.
  always_comb begin
    req_line             = '0;
    req_line[LINE_W-1:0] = bmem_addr[ADDR_W-1:BMEM_LINE_SHIFT];
  end

  // A read is only taken when no write starts or continues this cycle.
  assign rd_accept = bmem_read && bmem_ready && !bmem_write
                     && (wr_state == W_IDLE) && !q_full;

  // Write burst next state, RAM write strobe and protocol-error sources.
  always_comb begin
    wr_next  = wr_state;
    wr_en    = 1'b0;
    wr_start = 1'b0;
    wr_abort = 1'b0;
    collide  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (bmem_write && bmem_ready) begin
          wr_start = 1'b1;
          wr_en    = 1'b1;
          collide  = bmem_read;
          wr_next  = W_B1;
        end
      end
      W_B1: begin
        if (bmem_write) begin
          wr_en   = 1'b1;
          wr_next = W_B2;
        end else begin
          wr_abort = 1'b1;
          wr_next  = W_IDLE;
        end
      end
      W_B2: begin
        if (bmem_write) begin
          wr_en   = 1'b1;
          wr_next = W_B3;
        end else begin
          wr_abort = 1'b1;
          wr_next  = W_IDLE;
        end
      end
      W_B3: begin
        wr_next = W_IDLE;
        if (bmem_write) begin
          wr_en = 1'b1;
        end else begin
          wr_abort = 1'b1;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // The write state encoding doubles as the beat number being written.
  assign wr_beat = wr_state;
  assign wr_idx  = (wr_state == W_IDLE) ? bmem_addr[BMEM_LINE_SHIFT +: IDX_W]
                                        : wr_line_idx;

  // Read return next state; R_BEAT3 chains straight into the next aged line.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (head_ready) rd_next = R_BEAT0;
      R_BEAT0: rd_next = R_BEAT1;
      R_BEAT1: rd_next = R_BEAT2;
      R_BEAT2: rd_next = R_BEAT3;
      R_BEAT3: rd_next = second_ready ? R_BEAT0 : R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // The head leaves the queue as its last beat goes out; the following beat
  // (if any) is therefore fetched from the entry behind it.
  assign pop     = (rd_state == R_BEAT3) && !q_empty;
  assign rd_line = pop ? second_line : head_line;
  assign rd_idx  = rd_line[IDX_W-1:0];

  bmem_req_queue #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push         (rd_accept),
    .push_line    (req_line),
    .pop          (pop),
    .full         (q_full),
    .full_next    (q_full_next),
    .empty        (q_empty),
    .head_line    (head_line),
    .head_ready   (head_ready),
    .second_line  (second_line),
    .second_ready (second_ready)
  );

  // Backing store: beat b of every line lives in bank b.
  for (genvar b = 0; b < BMEM_BEATS; b++) begin : g_bank
    logic [BMEM_BEAT_W-1:0] mem [MEM_LINES];

    // Each bank only takes the beat whose number matches it.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_beat == 2'(b))) begin
        mem[wr_idx] <= bmem_wdata;
      end
    end

    assign bank_rd[b] = mem[rd_idx];
  end

`ifdef BMEM_RANDOM_STALL_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Free-running stall pattern generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  // Stalls never land inside a burst, so a started burst always completes.
  assign stall = (wr_next == W_IDLE) && (lfsr_next[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Ready looks ahead at next-cycle occupancy and burst state.
  assign ready_next = !q_full_next && (wr_next == W_IDLE) && !stall;

  // Both FSMs plus every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= W_IDLE;
      rd_state    <= R_IDLE;
      wr_line_idx <= '0;
      bmem_ready  <= 1'b0;
      bmem_rvalid <= 1'b0;
      bmem_raddr  <= '0;
      bmem_rdata  <= '0;
      proto_err   <= 1'b0;
    end else begin
      wr_state   <= wr_next;
      rd_state   <= rd_next;
      bmem_ready <= ready_next;
      if (wr_start) begin
        wr_line_idx <= bmem_addr[BMEM_LINE_SHIFT +: IDX_W];
      end
      if (collide || wr_abort) begin
        proto_err <= 1'b1;
      end
      bmem_rvalid <= (rd_next != R_IDLE);
      if (rd_next != R_IDLE) begin
        bmem_raddr <= {rd_line[LINE_W-1:0], {BMEM_LINE_SHIFT{1'b0}}};
        bmem_rdata <= bank_rd[rd_beat_idx(rd_next)];
      end else begin
        bmem_raddr <= '0;
        bmem_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmem_responder
// Purpose  : Directed self-checking bench for bmem_responder (default build).
// Revision : 1.0  initial release
// ============================================================================
module tb_bmem_responder;

  localparam int ADDR_W  = 32;
  localparam int LATENCY = 8;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic [ADDR_W-1:0] bmem_addr  = '0;
  logic              bmem_read  = 1'b0;
  logic              bmem_write = 1'b0;
  logic [63:0]       bmem_wdata = '0;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [63:0]       bmem_rdata;
  logic              bmem_rvalid;
  logic              proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bmem_responder #(
    .ADDR_W    (ADDR_W),
    .MEM_LINES (1024),
    .LATENCY   (LATENCY),
    .QDEPTH    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .proto_err   (proto_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a, input int b);
    return {a, 32'(b)};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (bmem_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bmem_ready !== 1'b1) check_eq("ready_timeout", 64'(bmem_ready), 64'd1);
  endtask

  // Write burst; abort_beat in 1..3 drops bmem_write at that beat (4 = none).
  task automatic wr_burst(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3, input int abort_beat);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    wait_ready();
    bmem_write = 1'b1;
    bmem_addr  = addr;
    bmem_wdata = d[0];
    tick();
    for (int b = 1; b < 4; b++) begin
      if (b == abort_beat) begin
        bmem_write = 1'b0;
        tick();
        break;
      end
      bmem_addr  = 32'hDEAD_BEE0;
      bmem_wdata = d[b];
      tick();
    end
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
  endtask

  task automatic wr_pat(input logic [31:0] addr);
    wr_burst(addr, pat(addr, 0), pat(addr, 1), pat(addr, 2), pat(addr, 3), 4);
  endtask

  // Single read with exact-latency and beat-order checks.
  task automatic read_check(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    wait_ready();
    bmem_read = 1'b1;
    bmem_addr = addr;
    tick();
    bmem_read = 1'b0;
    bmem_addr = '0;
    repeat (LATENCY - 2) tick();
    check_eq("rd_early_rvalid", 64'(bmem_rvalid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      check_eq("rd_rvalid", 64'(bmem_rvalid), 64'd1);
      check_eq("rd_raddr", 64'(bmem_raddr), 64'(addr));
      check_eq("rd_rdata", bmem_rdata, d[b]);
    end
    tick();
    check_eq("rd_after_rvalid", 64'(bmem_rvalid), 64'd0);
  endtask

  // Five reads into a 4-deep queue: back-pressure and gapless return.
  task automatic queue_full_test();
    logic [31:0] la [5];
    int          n_acc;
    int          nbeat;
    int          cyc;
    logic        acc;
    logic        rise_seen;
    n_acc = 0; nbeat = 0; cyc = 0; rise_seen = 1'b0;
    for (int i = 0; i < 5; i++) la[i] = 32'h3000 + 32'(i) * 32'h20;
    wait_ready();
    bmem_read = 1'b1;
    bmem_addr = la[0];
    for (int k = 0; k < 40; k++) begin
      acc = bmem_read && bmem_ready;
      tick();
      cyc++;
      if (acc) begin
        n_acc++;
        if (n_acc == 4) check_eq("qfull_ready_drop", 64'(bmem_ready), 64'd0);
        if (n_acc < 5) bmem_addr = la[n_acc];
        else begin
          bmem_read = 1'b0;
          bmem_addr = '0;
        end
      end
      if (n_acc == 4 && bmem_ready && !rise_seen) begin
        rise_seen = 1'b1;
        check_eq("qfull_ready_rise_cyc", 64'(cyc), 64'd12);
      end
      if (bmem_rvalid) begin
        if (nbeat < 20) begin
          check_eq("qfull_beat_cyc", 64'(cyc), 64'(8 + nbeat));
          check_eq("qfull_raddr", 64'(bmem_raddr), 64'(la[nbeat / 4]));
          check_eq("qfull_rdata", bmem_rdata, pat(la[nbeat / 4], nbeat % 4));
        end
        nbeat++;
      end
    end
    check_eq("qfull_nbeats", 64'(nbeat), 64'd20);
    check_eq("qfull_rise_seen", 64'(rise_seen), 64'd1);
  endtask

  initial begin
    int nv;

    // Reset: everything held low while rst is high.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_ready", 64'(bmem_ready), 64'd0);
      check_eq("rst_rvalid", 64'(bmem_rvalid), 64'd0);
    end
    check_eq("rst_raddr", 64'(bmem_raddr), 64'd0);
    check_eq("rst_rdata", bmem_rdata, 64'd0);
    check_eq("rst_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("ready_after_rst", 64'(bmem_ready), 64'd1);

    // Write then read back one line.
    wr_burst(32'h1000, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4);
    read_check(32'h1000, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);

    // Queue full / back-to-back return.
    for (int i = 0; i < 5; i++) wr_pat(32'h3000 + 32'(i) * 32'h20);
    queue_full_test();

    // Aborted burst keeps beats 0-1, leaves beats 2-3 untouched.
    wr_pat(32'h4000);
    check_eq("perr_before_abort", 64'(proto_err), 64'd0);
    wr_burst(32'h4000, pat(32'hBEEF_4000, 0), pat(32'hBEEF_4000, 1),
             pat(32'hBEEF_4000, 2), pat(32'hBEEF_4000, 3), 2);
    check_eq("perr_abort", 64'(proto_err), 64'd1);
    read_check(32'h4000, pat(32'hBEEF_4000, 0), pat(32'hBEEF_4000, 1),
               pat(32'h4000, 2), pat(32'h4000, 3));
    check_eq("perr_sticky", 64'(proto_err), 64'd1);

    // Clear the sticky flag.
    rst = 1'b1;
    tick();
    tick();
    check_eq("perr_cleared", 64'(proto_err), 64'd0);
    rst = 1'b0;
    tick();

    // Read/write collision: write wins, read dropped, error flagged.
    wait_ready();
    bmem_read  = 1'b1;
    bmem_write = 1'b1;
    bmem_addr  = 32'h2000;
    bmem_wdata = pat(32'hC011_2000, 0);
    tick();
    bmem_read = 1'b0;
    for (int b = 1; b < 4; b++) begin
      bmem_wdata = pat(32'hC011_2000, b);
      tick();
    end
    bmem_write = 1'b0;
    bmem_addr  = '0;
    check_eq("perr_collide", 64'(proto_err), 64'd1);
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      if (bmem_rvalid) nv++;
      tick();
    end
    check_eq("collide_no_rvalid", 64'(nv), 64'd0);
    read_check(32'h2000, pat(32'hC011_2000, 0), pat(32'hC011_2000, 1),
               pat(32'hC011_2000, 2), pat(32'hC011_2000, 3));

    // Reset in the middle of a read stream.
    wait_ready();
    bmem_read = 1'b1;
    bmem_addr = 32'h1000;
    tick();
    bmem_read = 1'b0;
    bmem_addr = '0;
    repeat (LATENCY - 1) tick();
    check_eq("mid_beat0_rvalid", 64'(bmem_rvalid), 64'd1);
    tick();
    check_eq("mid_beat1_rdata", bmem_rdata, 64'h2222_2222_2222_2222);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_rvalid", 64'(bmem_rvalid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("mid_ready_after", 64'(bmem_ready), 64'd1);
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      if (bmem_rvalid) nv++;
      tick();
    end
    check_eq("mid_no_stale_beats", 64'(nv), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
